// File: rtl/gold_iq_descrambler.sv
// Header-locked IQ quadrant (de)rotator driven by a two-LFSR Gold sequence.
// Tracks frame length with an optional overlength guard.
module gold_iq_descrambler #(
    parameter int              W         = 8,
    parameter logic [2*W-1:0]  HDR_WORD  = '1,
    parameter int              HDR_COUNT = 4,
    parameter logic [17:0]     SEED_X    = 18'h00001,
    parameter logic [17:0]     SEED_Y    = 18'h3FFFF,
    parameter int              MODE      = 0,
    parameter int              SAT       = 0,
    parameter int              RESEED    = 1,
    parameter int              LEN_W     = 16,
    parameter int              MAX_LEN   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2*W-1:0]   in_data,
    input  logic             in_valid,
    output logic [2*W-1:0]   out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             locked,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             len_err
);

    localparam int HC_W = (HDR_COUNT < 2) ? 1 : $clog2(HDR_COUNT + 1);
    localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(HDR_COUNT - 1);
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);
    localparam logic [W-1:0]     NEG_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     POS_MAX   = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        DATA = 2'b01
    } state_t;

    state_t             r_state;
    logic [HC_W-1:0]    r_hdr_cnt;
    logic [LEN_W-1:0]   r_len_cnt;
    logic [17:0]        r_x;
    logic [17:0]        r_y;
    logic               r_sof_armed;

    logic               w_is_hdr;
    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic [1:0]         w_r;
    logic [1:0]         w_k;
    logic [W-1:0]       w_i;
    logic [W-1:0]       w_q;
    logic [W-1:0]       w_re;
    logic [W-1:0]       w_im;
    logic [LEN_W-1:0]   w_len_next;
    logic               w_overlength;

    // With SAT the single unrepresentable negation clamps to the largest positive value.
    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        if ((SAT != 0) && (v == NEG_MIN)) begin
            return POS_MAX;
        end
        return -v;
    endfunction

    assign w_is_hdr = (in_data == HDR_WORD);
    assign w_i      = in_data[W-1:0];
    assign w_q      = in_data[2*W-1:W];

    assign w_a = r_x[5] ^ r_x[7] ^ r_x[16];
    assign w_b = ^{r_y[16:9], r_y[7:6]};
    assign w_d = r_x[1] ^ r_y[1];
    assign w_r = {w_a ^ w_b, w_d};
    assign w_k = (MODE != 0) ? (2'd0 - w_r) : w_r;

    assign w_len_next   = (r_len_cnt == '1) ? r_len_cnt : r_len_cnt + 1'b1;
    assign w_overlength = (MAX_LEN != 0) && (w_len_next == LEN_LIMIT);

    always_comb begin
        w_re = w_i;
        w_im = w_q;
        case (w_k)
            2'd1: begin
                w_re = w_q;
                w_im = negate(w_i);
            end
            2'd2: begin
                w_re = negate(w_i);
                w_im = negate(w_q);
            end
            2'd3: begin
                w_re = negate(w_q);
                w_im = w_i;
            end
            default: begin
                w_re = w_i;
                w_im = w_q;
            end
        endcase
    end

    assign locked = (r_state == DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_hdr_cnt   <= '0;
            r_len_cnt   <= '0;
            r_x         <= SEED_X;
            r_y         <= SEED_Y;
            r_sof_armed <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            len_err     <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            if ((r_state != HUNT) && (r_state != DATA)) begin
                r_state   <= HUNT;
                r_hdr_cnt <= '0;
            end else if (in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (!w_is_hdr) begin
                            r_hdr_cnt <= '0;
                        end else if (r_hdr_cnt >= HC_LAST) begin
                            r_state     <= DATA;
                            r_hdr_cnt   <= '0;
                            r_len_cnt   <= '0;
                            r_sof_armed <= 1'b1;
                            if (RESEED != 0) begin
                                r_x <= SEED_X;
                                r_y <= SEED_Y;
                            end
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        // A header closes the frame and already counts toward the next lock.
                        if (w_is_hdr) begin
                            frame_done <= 1'b1;
                            frame_len  <= r_len_cnt;
                            r_state    <= HUNT;
                            r_hdr_cnt  <= HC_W'(1);
                        end else begin
                            out_data    <= {w_im, w_re};
                            out_valid   <= 1'b1;
                            out_sof     <= r_sof_armed;
                            r_sof_armed <= 1'b0;
                            r_len_cnt   <= w_len_next;
                            r_x         <= {r_x[0] ^ r_x[7], r_x[17:1]};
                            r_y         <= {r_y[0] ^ r_y[5] ^ r_y[7] ^ r_y[10], r_y[17:1]};
                            if (w_overlength) begin
                                frame_done <= 1'b1;
                                len_err    <= 1'b1;
                                frame_len  <= LEN_LIMIT;
                                r_state    <= HUNT;
                                r_hdr_cnt  <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state   <= HUNT;
                        r_hdr_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
